// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and constants used by the word arbiter.
package trdb_pkg;

    localparam int unsigned XLEN = 32;

    // Frames a software dump word; never produced by the stream aligner.
    localparam logic [XLEN-1:0] DUMP_MARKER = 32'hFFFF_FFFF;

    typedef enum logic {
        ARB  = 1'b0,
        DUMP = 1'b1
    } trdb_arb_state_t;

endpackage

// File: rtl/trdb_fifo.sv
// Generic synchronous FIFO with push/pop/flush; push is refused when full,
// even if a pop happens in the same cycle.
module trdb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // An empty FIFO presents zero so the head word is defined out of reset.
    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count_q and empty entries are masked on data_o.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/trdb_word_arbiter.sv
// Merges aligned trace words and framed software dump words into one
// buffered packet word stream; bounds dump starvation with a wait counter.
module trdb_word_arbiter
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic [XLEN-1:0] trace_word_i,
    input  logic            trace_valid_i,
    output logic            trace_ready_o,
    input  logic [XLEN-1:0] dump_word_i,
    input  logic            dump_valid_i,
    output logic            dump_ready_o,
    output logic [XLEN-1:0] word_o,
    output logic            word_valid_o,
    input  logic            stall_i,
    output logic            fifo_full_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned WW      = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [WW-1:0] MAX_C = MAX_WAIT[WW-1:0];

    trdb_arb_state_t state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW:0]     count;
    logic [AW:0]     free;
    logic            empty;
    logic            push;
    logic [XLEN-1:0] push_data;
    logic            dump_sel;

    // Free slots come from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign free     = DEPTH_C - count;
    assign dump_sel = dump_valid_i && (free >= 2) &&
                      (!trace_valid_i || wait_q == MAX_C);

    // State register and dump wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Arbitration: choose the pushed word, drive readies, compute next state.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        push          = 1'b0;
        push_data     = trace_word_i;
        trace_ready_o = 1'b0;
        dump_ready_o  = 1'b0;
        if (!enable_i) begin
            state_d = ARB;
            wait_d  = '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (dump_sel) begin
                        push      = 1'b1;
                        push_data = DUMP_MARKER;
                        state_d   = DUMP;
                        wait_d    = '0;
                    end else begin
                        if (trace_valid_i && free >= 1) begin
                            push          = 1'b1;
                            trace_ready_o = 1'b1;
                        end
                        if (!dump_valid_i) wait_d = '0;
                        else if (wait_q != MAX_C) wait_d = wait_q + 1'b1;
                    end
                end
                DUMP: begin
                    push         = 1'b1;
                    push_data    = dump_word_i;
                    dump_ready_o = 1'b1;
                    state_d      = ARB;
                    wait_d       = '0;
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign word_valid_o = !empty;

    trdb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (!enable_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (word_valid_o && !stall_i),
        .data_o  (word_o),
        .full_o  (fifo_full_o),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_trdb_word_arbiter.sv
// Directed testbench for trdb_word_arbiter (DEPTH = 4, MAX_WAIT = 8).
module tb_trdb_word_arbiter;
    import trdb_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            enable_i;
    logic [XLEN-1:0] trace_word_i;
    logic            trace_valid_i;
    logic            trace_ready_o;
    logic [XLEN-1:0] dump_word_i;
    logic            dump_valid_i;
    logic            dump_ready_o;
    logic [XLEN-1:0] word_o;
    logic            word_valid_o;
    logic            stall_i;
    logic            fifo_full_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] MARK = 32'hFFFF_FFFF;

    trdb_word_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .trace_word_i  (trace_word_i),
        .trace_valid_i (trace_valid_i),
        .trace_ready_o (trace_ready_o),
        .dump_word_i   (dump_word_i),
        .dump_valid_i  (dump_valid_i),
        .dump_ready_o  (dump_ready_o),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .stall_i       (stall_i),
        .fifo_full_o   (fifo_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 2 time units after the edge.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rst_ni        = 1'b0;
        enable_i      = 1'b0;
        trace_word_i  = '0;
        trace_valid_i = 1'b0;
        dump_word_i   = '0;
        dump_valid_i  = 1'b0;
        stall_i       = 1'b0;

        // ---- reset state
        tick();
        check("rst_word", word_o, 32'h0);
        check("rst_valid", {31'b0, word_valid_o}, 32'h0);
        check("rst_full", {31'b0, fifo_full_o}, 32'h0);
        check("rst_tready", {31'b0, trace_ready_o}, 32'h0);
        check("rst_dready", {31'b0, dump_ready_o}, 32'h0);
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        tick();

        // ---- trace A0..A3, no stall: each word appears one cycle after push
        for (int i = 0; i < 4; i++) begin
            trace_valid_i = 1'b1;
            trace_word_i  = 32'hA000_0000 + i;
            #1;
            check("a_tready", {31'b0, trace_ready_o}, 32'h1);
            check("a_dready", {31'b0, dump_ready_o}, 32'h0);
            tick();
            check("a_word", word_o, 32'hA000_0000 + i);
            check("a_valid", {31'b0, word_valid_o}, 32'h1);
        end
        trace_valid_i = 1'b0;
        tick();
        check("a_drained", {31'b0, word_valid_o}, 32'h0);

        // ---- single dump, trace idle: marker then payload
        dump_valid_i = 1'b1;
        dump_word_i  = 32'h1234_5678;
        #1;
        check("d_dready_arb", {31'b0, dump_ready_o}, 32'h0);
        tick();
        check("d_marker", word_o, MARK);
        check("d_dready_dump", {31'b0, dump_ready_o}, 32'h1);
        tick();
        dump_valid_i = 1'b0;
        check("d_payload", word_o, 32'h1234_5678);
        #1;
        check("d_dready_after", {31'b0, dump_ready_o}, 32'h0);
        tick();
        check("d_drained", {31'b0, word_valid_o}, 32'h0);

        // ---- stall fills the FIFO
        stall_i       = 1'b1;
        trace_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            trace_word_i = 32'hB000_0000 + i;
            #1;
            check("s_tready", {31'b0, trace_ready_o}, 32'h1);
            tick();
        end
        trace_word_i = 32'hB000_0004;
        #1;
        check("s_full", {31'b0, fifo_full_o}, 32'h1);
        check("s_tready_full", {31'b0, trace_ready_o}, 32'h0);
        check("s_hold", word_o, 32'hB000_0000);
        tick();
        check("s_hold2", word_o, 32'hB000_0000);
        // Release stall while full: the same-cycle pop does not admit a push.
        stall_i = 1'b0;
        #1;
        check("s_refuse_on_pop", {31'b0, trace_ready_o}, 32'h0);
        tick();
        trace_valid_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("s_drain", word_o, 32'hB000_0000 + i);
            tick();
        end
        check("s_drained", {31'b0, word_valid_o}, 32'h0);

        // ---- starvation bound: 8 trace words, then marker + dump
        trace_valid_i = 1'b1;
        dump_valid_i  = 1'b1;
        dump_word_i   = 32'h5555_AAAA;
        for (int i = 0; i < 8; i++) begin
            trace_word_i = 32'hC000_0000 + i;
            #1;
            check("w_tready", {31'b0, trace_ready_o}, 32'h1);
            check("w_dready", {31'b0, dump_ready_o}, 32'h0);
            tick();
            check("w_word", word_o, 32'hC000_0000 + i);
        end
        trace_word_i = 32'hC000_0008;
        #1;
        check("w_forced", {31'b0, trace_ready_o}, 32'h0);
        tick();
        check("w_marker", word_o, MARK);
        check("w_dready", {31'b0, dump_ready_o}, 32'h1);
        check("w_tready_dump", {31'b0, trace_ready_o}, 32'h0);
        check("w_wait_clr", 32'(dut.wait_q), 32'h0);
        tick();
        dump_valid_i = 1'b0;
        check("w_payload", word_o, 32'h5555_AAAA);
        #1;
        check("w_tready_resume", {31'b0, trace_ready_o}, 32'h1);
        tick();
        trace_valid_i = 1'b0;
        check("w_after", word_o, 32'hC000_0008);
        check("w_wait_zero", 32'(dut.wait_q), 32'h0);
        tick();
        check("w_drained", {31'b0, word_valid_o}, 32'h0);

        // ---- 3 of 4 entries with a dump pending: wait for two free slots
        stall_i       = 1'b1;
        trace_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trace_word_i = 32'hD000_0000 + i;
            tick();
        end
        trace_valid_i = 1'b0;
        dump_valid_i  = 1'b1;
        dump_word_i   = 32'hCAFE_0001;
        tick();
        check("f_refused", {31'b0, dump_ready_o}, 32'h0);
        check("f_head", word_o, 32'hD000_0000);
        check("f_not_full", {31'b0, fifo_full_o}, 32'h0);
        stall_i = 1'b0;
        tick();
        check("f_still_arb", {31'b0, dump_ready_o}, 32'h0);
        check("f_d1", word_o, 32'hD000_0001);
        tick();
        check("f_in_dump", {31'b0, dump_ready_o}, 32'h1);
        check("f_d2", word_o, 32'hD000_0002);
        tick();
        dump_valid_i = 1'b0;
        check("f_marker", word_o, MARK);
        tick();
        check("f_payload", word_o, 32'hCAFE_0001);
        tick();
        check("f_drained", {31'b0, word_valid_o}, 32'h0);

        // ---- disable during DUMP discards the marker; re-enable resends
        dump_valid_i = 1'b1;
        dump_word_i  = 32'h0BAD_F00D;
        tick();
        check("e_marker_head", word_o, MARK);
        enable_i = 1'b0;
        #1;
        check("e_dready_off", {31'b0, dump_ready_o}, 32'h0);
        tick();
        check("e_flushed", {31'b0, word_valid_o}, 32'h0);
        check("e_word_zero", word_o, 32'h0);
        enable_i = 1'b1;
        #1;
        check("e_rearb", {31'b0, dump_ready_o}, 32'h0);
        tick();
        check("e_marker2", word_o, MARK);
        check("e_dready2", {31'b0, dump_ready_o}, 32'h1);
        tick();
        dump_valid_i = 1'b0;
        check("e_payload", word_o, 32'h0BAD_F00D);
        tick();
        check("e_drained", {31'b0, word_valid_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
